// File: rtl/mips_pc_redirect_if.sv
// Fetch-side bundle for mips_pc_redirect.
// It carries the branch/jump redirect requests from the ID stage, the hazard
// stall, the imem fetch handshake and the debug counter.
//   master : the ID-stage branch unit, hazard unit and imem port, all driving the PC owner
//   slave  : the PC owner (mips_pc_redirect)
interface mips_pc_redirect_if #(
    parameter int DATA_32_W = 32,
    parameter int CNT_W     = 16
);
    logic                 beq_valid;
    logic [DATA_32_W-1:0] beq_target;
    logic                 jump_valid;
    logic [DATA_32_W-1:0] jump_target;
    logic                 stall_if;
    logic                 imem_ready;
    logic                 imem_req_valid;
    logic [DATA_32_W-1:0] pc_out;
    logic [DATA_32_W-1:0] pc_plus4;
    logic                 flush_if_id;
    logic                 redirect_pend;
    logic [CNT_W-1:0]     redirect_cnt;

    modport master (
        output beq_valid, beq_target, jump_valid, jump_target, stall_if, imem_ready,
        input  imem_req_valid, pc_out, pc_plus4, flush_if_id, redirect_pend, redirect_cnt
    );

    modport slave (
        input  beq_valid, beq_target, jump_valid, jump_target, stall_if, imem_ready,
        output imem_req_valid, pc_out, pc_plus4, flush_if_id, redirect_pend, redirect_cnt
    );
endinterface

// File: rtl/mips_pc_redirect.sv
// mips_pc_redirect: owns the fetch PC.
// It applies taken-BEQ and jump redirects, raises the IF/ID flush, and holds
// a redirect that arrives while fetch cannot advance. It also counts applied
// redirects in a saturating counter.
// Ports:
//   clk_i-style clk : rising-edge clock
//   rst             : asynchronous, active-high reset
//   bus (slave)     : redirect requests, stall/imem handshake, PC outputs,
//                     flush, pending flag, redirect counter
//
// state | meaning
// ------+------------------------------------------------------------
// RUN   | normal fetch; a redirect is applied at once if fetch advances
// PEND  | redirect latched in pend_target_q, waiting for fetch to advance
module mips_pc_redirect #(
    parameter int                   DATA_32_W = 32,
    parameter logic [DATA_32_W-1:0] RESET_PC  = 32'h0040_0000,
    parameter int                   CNT_W     = 16
) (
    input logic              clk,
    input logic              rst,
    mips_pc_redirect_if.slave bus
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_PEND = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [DATA_32_W-1:0] pc_q, pc_d;
    logic [DATA_32_W-1:0] pend_target_q, pend_target_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [DATA_32_W-1:0] pc_plus4;
    logic [DATA_32_W-1:0] redir_target;
    logic                 advance;
    logic                 redir;
    logic                 apply_redir;

    assign pc_plus4 = pc_q + DATA_32_W'(4);

    always_comb begin
        advance      = !bus.stall_if && bus.imem_ready;
        redir        = bus.beq_valid || bus.jump_valid;
        // BEQ wins if both fire; targets are always word-aligned.
        redir_target = bus.beq_valid ? bus.beq_target : bus.jump_target;
        redir_target[1:0] = 2'b00;

        state_d       = state_q;
        pc_d          = pc_q;
        pend_target_d = pend_target_q;
        cnt_d         = cnt_q;
        apply_redir   = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (redir) begin
                    if (advance) begin
                        pc_d        = redir_target;
                        apply_redir = 1'b1;
                    end else begin
                        pend_target_d = redir_target;
                        state_d       = ST_PEND;
                    end
                end else if (advance) begin
                    pc_d = pc_plus4;
                end
            end
            ST_PEND: begin
                // Any redirect seen here comes from a younger, wrong-path
                // instruction, so it is dropped.
                if (advance) begin
                    pc_d        = pend_target_q;
                    apply_redir = 1'b1;
                    state_d     = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase

        if (apply_redir && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_RUN;
            pc_q          <= RESET_PC;
            pend_target_q <= '0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pend_target_q <= pend_target_d;
            cnt_q         <= cnt_d;
        end
    end

    // Control outputs are forced low during reset. The redirect inputs may
    // still be toggling at that time.
    assign bus.imem_req_valid = !rst;
    assign bus.flush_if_id    = !rst && (((state_q == ST_RUN) && redir) || (state_q == ST_PEND));
    assign bus.redirect_pend  = !rst && (state_q == ST_PEND);
    assign bus.pc_out         = pc_q;
    assign bus.pc_plus4       = pc_plus4;
    assign bus.redirect_cnt   = cnt_q;

endmodule

// File: tb/tb_mips_pc_redirect.sv
// Testbench for mips_pc_redirect.
// Two DUTs receive identical stimulus: one with a 16-bit counter and one with
// a 2-bit counter, so that counter saturation can be seen.
module tb_mips_pc_redirect;

    localparam logic [31:0] RESET_PC = 32'h0040_0000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mips_pc_redirect_if #(.DATA_32_W(32), .CNT_W(16)) if_a ();
    mips_pc_redirect_if #(.DATA_32_W(32), .CNT_W(2))  if_s ();

    mips_pc_redirect #(.DATA_32_W(32), .RESET_PC(RESET_PC), .CNT_W(16)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (if_a.slave)
    );

    mips_pc_redirect #(.DATA_32_W(32), .RESET_PC(RESET_PC), .CNT_W(2)) u_sat (
        .clk (clk),
        .rst (rst),
        .bus (if_s.slave)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model, kept as abstract facts rather than as an FSM.
    logic [31:0] m_pc;
    logic        m_pend;
    logic [31:0] m_pt;
    int          m_applied;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] sat3(input int n);
        return (n > 3) ? 32'd3 : 32'(n);
    endfunction

    task automatic drive(input logic bv, input logic [31:0] bt, input logic jv,
                         input logic [31:0] jt, input logic st, input logic rd);
        if_a.beq_valid = bv; if_a.beq_target = bt; if_a.jump_valid = jv;
        if_a.jump_target = jt; if_a.stall_if = st; if_a.imem_ready = rd;
        if_s.beq_valid = bv; if_s.beq_target = bt; if_s.jump_valid = jv;
        if_s.jump_target = jt; if_s.stall_if = st; if_s.imem_ready = rd;
    endtask

    task automatic model_reset();
        m_pc = RESET_PC; m_pend = 1'b0; m_pt = 32'h0; m_applied = 0;
    endtask

    // Called at a negedge. Drives one cycle of inputs and checks the
    // combinational outputs. Then crosses the rising edge and checks the
    // registered outputs at the following negedge.
    task automatic step(input logic bv, input logic [31:0] bt, input logic jv,
                        input logic [31:0] jt, input logic st, input logic rd,
                        output logic obs_flush);
        logic        redir;
        logic        adv;
        logic [31:0] tgt;
        drive(bv, bt, jv, jt, st, rd);
        if (bv && jv) $display("note: illegal overlap of beq_valid and jump_valid at %0t", $time);
        #1;
        redir = bv | jv;
        adv   = !st && rd;
        tgt   = (bv ? bt : jt) & 32'hFFFF_FFFC;
        obs_flush = if_a.flush_if_id;
        chk("flush_if_id", {31'b0, if_a.flush_if_id}, {31'b0, m_pend | redir});
        chk("pc_plus4", if_a.pc_plus4, m_pc + 32'd4);
        chk("imem_req_valid", {31'b0, if_a.imem_req_valid}, 32'd1);
        if (m_pend) begin
            if (adv) begin
                m_pc = m_pt; m_pend = 1'b0; m_applied++;
            end
        end else if (redir) begin
            if (adv) begin
                m_pc = tgt; m_applied++;
            end else begin
                m_pend = 1'b1; m_pt = tgt;
            end
        end else if (adv) begin
            m_pc = m_pc + 32'd4;
        end
        @(posedge clk);
        @(negedge clk);
        chk("pc_out", if_a.pc_out, m_pc);
        chk("redirect_pend", {31'b0, if_a.redirect_pend}, {31'b0, m_pend});
        chk("redirect_cnt", {16'b0, if_a.redirect_cnt}, 32'(m_applied));
        chk("sat_cnt", {30'b0, if_s.redirect_cnt}, sat3(m_applied));
    endtask

    typedef struct {
        logic        bv;
        logic [31:0] bt;
        logic        jv;
        logic [31:0] jt;
        logic        st;
        logic        rd;
        logic        e_flush;
        logic [31:0] e_pc;
        logic        e_pend;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t tbl[12];

    initial begin
        logic fl;
        tbl[0]  = '{1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 32'h0040_0004, 1'b0, 16'd0};
        tbl[1]  = '{1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 32'h0040_0008, 1'b0, 16'd0};
        tbl[2]  = '{1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 32'h0040_000C, 1'b0, 16'd0};
        tbl[3]  = '{1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 32'h0040_0010, 1'b0, 16'd0};
        tbl[4]  = '{1'b1, 32'h0040_0040, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 32'h0040_0040, 1'b0, 16'd1};
        tbl[5]  = '{1'b0, 32'h0,         1'b1, 32'h0040_0100, 1'b0, 1'b0, 1'b1, 32'h0040_0040, 1'b1, 16'd1};
        tbl[6]  = '{1'b0, 32'h0,         1'b1, 32'h0040_0100, 1'b0, 1'b0, 1'b1, 32'h0040_0040, 1'b1, 16'd1};
        tbl[7]  = '{1'b1, 32'h0040_0200, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 32'h0040_0040, 1'b1, 16'd1};
        tbl[8]  = '{1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 32'h0040_0100, 1'b0, 16'd2};
        tbl[9]  = '{1'b1, 32'h0040_0022, 1'b1, 32'h0040_0800, 1'b0, 1'b1, 1'b1, 32'h0040_0020, 1'b0, 16'd3};
        tbl[10] = '{1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 32'h0040_0020, 1'b0, 16'd3};
        tbl[11] = '{1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 32'h0040_0024, 1'b0, 16'd3};

        // Reset is held with a redirect request active. The control outputs
        // must stay quiet during reset.
        rst = 1'b1;
        drive(1'b1, 32'h0040_0040, 1'b0, 32'h0, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        #1;
        chk("rst_pc_out", if_a.pc_out, RESET_PC);
        chk("rst_req_valid", {31'b0, if_a.imem_req_valid}, 32'd0);
        chk("rst_flush", {31'b0, if_a.flush_if_id}, 32'd0);
        chk("rst_pend", {31'b0, if_a.redirect_pend}, 32'd0);
        chk("rst_cnt", {16'b0, if_a.redirect_cnt}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        for (int i = 0; i < 12; i++) begin
            step(tbl[i].bv, tbl[i].bt, tbl[i].jv, tbl[i].jt, tbl[i].st, tbl[i].rd, fl);
            chk($sformatf("tbl%0d_flush", i), {31'b0, fl}, {31'b0, tbl[i].e_flush});
            chk($sformatf("tbl%0d_pc", i), if_a.pc_out, tbl[i].e_pc);
            chk($sformatf("tbl%0d_pend", i), {31'b0, if_a.redirect_pend}, {31'b0, tbl[i].e_pend});
            chk($sformatf("tbl%0d_cnt", i), {16'b0, if_a.redirect_cnt}, {16'b0, tbl[i].e_cnt});
        end

        // Check PC wrap-around at the top of the address space, then check
        // that the 2-bit counter has saturated.
        step(1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1, fl);
        chk("wrap_pc_top", if_a.pc_out, 32'hFFFF_FFFC);
        #1;
        chk("wrap_plus4", if_a.pc_plus4, 32'h0000_0000);
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, fl);
        chk("wrap_pc_zero", if_a.pc_out, 32'h0000_0000);
        chk("sat_cnt_hold", {30'b0, if_s.redirect_cnt}, 32'd3);
        chk("cnt_after_wrap", {16'b0, if_a.redirect_cnt}, 32'd4);

        // Randomized traffic, checked against the model.
        for (int i = 0; i < 400; i++) begin
            int unsigned kind;
            kind = $urandom_range(0, 7);
            step(kind == 0, $urandom, kind == 1, $urandom,
                 $urandom_range(0, 4) == 0, $urandom_range(0, 9) < 7, fl);
        end

        // Reset arrives while a redirect is pending. The pending target must
        // be discarded.
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, fl);
        step(1'b0, 32'h0, 1'b1, 32'h0040_0300, 1'b0, 1'b0, fl);
        chk("pre_rst_pend", {31'b0, if_a.redirect_pend}, 32'd1);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("midpend_rst_pc", if_a.pc_out, RESET_PC);
        chk("midpend_rst_pend", {31'b0, if_a.redirect_pend}, 32'd0);
        chk("midpend_rst_flush", {31'b0, if_a.flush_if_id}, 32'd0);
        chk("midpend_rst_cnt", {16'b0, if_a.redirect_cnt}, 32'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, fl);
        chk("post_rst_pc", if_a.pc_out, 32'h0040_0004);
        chk("post_rst_flush", {31'b0, fl}, 32'd0);
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, fl);
        chk("post_rst_pc2", if_a.pc_out, 32'h0040_0008);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
